// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine feeding HI/LO.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes on the way in, two's-complement
// correction of the product or of quotient/remainder on the way out.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_hi,
  input  logic [WIDTH-1:0] val_lo,
  input  logic             neg_hi,
  input  logic             neg_lo,
  input  logic             wide,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  logic [2*WIDTH-1:0] wide_val;
  logic [2*WIDTH-1:0] wide_neg;

  assign wide_val = {val_hi, val_lo};
  assign wide_neg = -wide_val;

  // In wide mode the pair is one 2*WIDTH value and neg_hi alone selects negation.
  always_comb begin
    out_hi = neg_hi ? -val_hi : val_hi;
    out_lo = neg_lo ? -val_lo : val_lo;
    if (wide) begin
      {out_hi, out_lo} = neg_hi ? wide_neg : wide_val;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Shared shift-add multiplier / restoring divider producing HI/LO, with a
// start/busy/done handshake and an early divide-by-zero completion.
//
// state | meaning
// IDLE  | waiting for start; operands, signs and op latched on start
// MUL   | one shift-add step per cycle, WIDTH cycles
// DIV   | one restoring quotient bit per cycle, WIDTH cycles
// FIN   | sign correction, hi/lo load, done pulse
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic               neg_hi_r;
  logic               neg_lo_r;
  logic               is_div_r;
  logic               dz_r;

  logic               op_signed;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sign_a    = op_signed & a[WIDTH-1];
  assign sign_b    = op_signed & b[WIDTH-1];

  // A signed MIN operand yields 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  muldiv_signfix #(.WIDTH(WIDTH)) u_pre (
    .val_hi (a),
    .val_lo (b),
    .neg_hi (sign_a),
    .neg_lo (sign_b),
    .wide   (1'b0),
    .out_hi (a_mag),
    .out_lo (b_mag)
  );

  muldiv_signfix #(.WIDTH(WIDTH)) u_post (
    .val_hi (acc[2*WIDTH-1:WIDTH]),
    .val_lo (acc[WIDTH-1:0]),
    .neg_hi (neg_hi_r),
    .neg_lo (neg_lo_r),
    .wide   (~is_div_r),
    .out_hi (res_hi),
    .out_lo (res_lo)
  );

  // Multiply: acc = {partial, multiplier}; the carry out of the add shifts back in.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; trial is the remainder shifted in one bit.
  assign div_trial = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_trial >= {1'b0, mcand};
  assign div_diff  = div_trial[WIDTH-1:0] - mcand;
  assign div_next  = {(div_ge ? div_diff : div_trial[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op[1])         state_nxt = MUL;
          else if (b == '0)   state_nxt = FIN;
          else                state_nxt = DIV;
        end
      end
      MUL, DIV: begin
        if (cnt == CNT_LAST) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
      neg_hi_r <= 1'b0;
      neg_lo_r <= 1'b0;
      is_div_r <= 1'b0;
      dz_r     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            mcand    <= op[1] ? b_mag : a_mag;
            cnt      <= '0;
            is_div_r <= op[1];
            dz_r     <= op[1] & (b == '0);
            neg_lo_r <= sign_a ^ sign_b;
            neg_hi_r <= op[1] ? sign_a : (sign_a ^ sign_b);
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt + CNT_W'(1);
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          done     <= 1'b1;
          div_zero <= dz_r;
          if (!dz_r) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit at WIDTH=32 plus one WIDTH=8 case.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8    = 2'b00;
  logic [7:0]  a8     = '0;
  logic [7:0]  b8     = '0;
  logic        busy8, done8, div_zero8;
  logic [7:0]  hi8, lo8;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          edges;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic e_dz, input int e_edges);
    exp_t e;
    e.tag = tag; e.hi = e_hi; e.lo = e_lo; e.dz = e_dz; e.edges = e_edges;
    sb_q.push_back(e);
  endtask

  // Returns #1 after the start edge with start already dropped.
  task automatic launch(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    @(negedge clock);
    op = op_i; a = a_i; b = b_i; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // edges0 = edges already elapsed counting the start edge as 1.
  task automatic finish_op(input int edges0);
    int   edges;
    exp_t e;
    edges = edges0;
    while (done !== 1'b1 && edges < 200) begin
      @(posedge clock); #1;
      edges++;
    end
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ":done"},     64'(done),     64'd1);
      chk({e.tag, ":edges"},    64'(edges),    64'(e.edges));
      chk({e.tag, ":busy"},     64'(busy),     64'd0);
      chk({e.tag, ":div_zero"}, 64'(div_zero), 64'(e.dz));
      chk({e.tag, ":hi"},       64'(hi),       64'(e.hi));
      chk({e.tag, ":lo"},       64'(lo),       64'(e.lo));
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op_i, input logic [31:0] a_i,
                       input logic [31:0] b_i, input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input logic e_dz, input int e_edges);
    push_exp(tag, e_hi, e_lo, e_dz, e_edges);
    launch(op_i, a_i, b_i);
    finish_op(1);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [63:0] prod;
    longint      sa, sbv, q, r;
    logic [63:0] qv, rv;
    int          pulses;
    int          edges8;

    #12;
    chk("reset:busy",     64'(busy),     64'd0);
    chk("reset:done",     64'(done),     64'd0);
    chk("reset:div_zero", 64'(div_zero), 64'd0);
    chk("reset:hi",       64'(hi),       64'd0);
    chk("reset:lo",       64'(lo),       64'd0);
    @(negedge clock); reset = 1'b1;
    repeat (2) @(posedge clock);

    do_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34);
    do_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
    do_op("mult_m1xm1",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34);
    do_op("div_neg7_2",  2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    do_op("div_7_neg2",  2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34);
    do_op("divu_100_7",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 34);
    do_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34);
    do_op("div_min_m1",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34);

    do_op("divu_by0",    2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 2);
    @(posedge clock); #1;
    chk("divu_by0:done_width", 64'(done),     64'd0);
    chk("divu_by0:dz_width",   64'(div_zero), 64'd0);

    for (int i = 0; i < 8; i++) begin
      r_op = 2'(i % 4);
      r_a  = $urandom;
      r_b  = $urandom;
      if (i >= 4) r_b = r_b >> (i * 3);
      if (r_b == '0) r_b = 32'd3;
      case (r_op)
        2'b00: prod = 64'(longint'($signed(r_a)) * longint'($signed(r_b)));
        2'b01: prod = {32'd0, r_a} * {32'd0, r_b};
        default: begin
          if (r_op == 2'b10) begin
            sa = longint'($signed(r_a)); sbv = longint'($signed(r_b));
          end else begin
            sa = longint'({32'd0, r_a}); sbv = longint'({32'd0, r_b});
          end
          q = sa / sbv; r = sa % sbv;
          qv = 64'(q); rv = 64'(r);
          prod = {rv[31:0], qv[31:0]};
        end
      endcase
      do_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, prod[63:32], prod[31:0], 1'b0, 34);
    end

    // Second start while busy must be ignored.
    push_exp("busy_ignore", 32'd0, 32'd12, 1'b0, 34);
    launch(2'b01, 32'd3, 32'd4);
    repeat (4) begin @(posedge clock); #1; end
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    finish_op(6);
    pulses = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    chk("busy_ignore:extra_done", 64'(pulses), 64'd0);

    // Start raised during the done cycle is accepted.
    push_exp("b2b_first",  32'd0, 32'd30, 1'b0, 34);
    push_exp("b2b_second", 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 34);
    launch(2'b01, 32'd5, 32'd6);
    finish_op(1);
    op = 2'b00; a = 32'hFFFF_FFFF; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    finish_op(1);

    // Asynchronous reset mid-multiply.
    launch(2'b01, 32'd11, 32'd13);
    repeat (9) begin @(posedge clock); #1; end
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    chk("async_reset:busy",     64'(busy),     64'd0);
    chk("async_reset:done",     64'(done),     64'd0);
    chk("async_reset:div_zero", 64'(div_zero), 64'd0);
    chk("async_reset:hi",       64'(hi),       64'd0);
    chk("async_reset:lo",       64'(lo),       64'd0);
    @(negedge clock); reset = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    chk("async_reset:no_done", 64'(pulses), 64'd0);

    // WIDTH=8 instance.
    @(negedge clock);
    op8 = 2'b00; a8 = 8'h81; b8 = 8'h02; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    edges8 = 1;
    while (done8 !== 1'b1 && edges8 < 100) begin
      @(posedge clock); #1;
      edges8++;
    end
    chk("w8_mult:done",  64'(done8),  64'd1);
    chk("w8_mult:edges", 64'(edges8), 64'd10);
    chk("w8_mult:busy",  64'(busy8),  64'd0);
    chk("w8_mult:hi",    64'(hi8),    64'hFF);
    chk("w8_mult:lo",    64'(lo8),    64'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
